// File: rtl/eth_tx_frame_arbiter_if.sv
// Requester-side and tx-core-side handshake bundle for eth_tx_frame_arbiter.
// master = arbiter view, slave = environment (requesters + tx core) view.
interface eth_tx_frame_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req_hdr_valid;
  logic [NUM_REQ-1:0]    req_hdr_ready;
  logic [48*NUM_REQ-1:0] req_dest_mac;
  logic [48*NUM_REQ-1:0] req_src_mac;
  logic [16*NUM_REQ-1:0] req_eth_type;
  logic [8*NUM_REQ-1:0]  req_tdata;
  logic [NUM_REQ-1:0]    req_tvalid;
  logic [NUM_REQ-1:0]    req_tlast;
  logic [NUM_REQ-1:0]    req_tready;

  logic        s_eth_hdr_valid;
  logic        s_eth_hdr_ready;
  logic [47:0] s_eth_dest_mac;
  logic [47:0] s_eth_src_mac;
  logic [15:0] s_eth_type;
  logic [7:0]  s_eth_payload_axis_tdata;
  logic        s_eth_payload_axis_tvalid;
  logic        s_eth_payload_axis_tlast;
  logic        s_eth_payload_axis_tuser;
  logic        s_eth_payload_axis_tready;

  modport master (
    input  req_hdr_valid, req_dest_mac, req_src_mac, req_eth_type,
    input  req_tdata, req_tvalid, req_tlast,
    output req_hdr_ready, req_tready,
    output s_eth_hdr_valid, s_eth_dest_mac, s_eth_src_mac, s_eth_type,
    output s_eth_payload_axis_tdata, s_eth_payload_axis_tvalid,
    output s_eth_payload_axis_tlast, s_eth_payload_axis_tuser,
    input  s_eth_hdr_ready, s_eth_payload_axis_tready
  );

  modport slave (
    output req_hdr_valid, req_dest_mac, req_src_mac, req_eth_type,
    output req_tdata, req_tvalid, req_tlast,
    input  req_hdr_ready, req_tready,
    input  s_eth_hdr_valid, s_eth_dest_mac, s_eth_src_mac, s_eth_type,
    input  s_eth_payload_axis_tdata, s_eth_payload_axis_tvalid,
    input  s_eth_payload_axis_tlast, s_eth_payload_axis_tuser,
    output s_eth_hdr_ready, s_eth_payload_axis_tready
  );
endinterface

// File: rtl/eth_tx_frame_arbiter.sv
// Per-frame round-robin arbiter sharing one eth header+payload tx port among NUM_REQ
// requesters; stalled payloads are cut with a tuser-marked byte and drained.
module eth_tx_frame_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int IDLE_TIMEOUT = 256,
  parameter int TO_W         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  eth_tx_frame_arbiter_if.master bus,
  input  logic                  arg_busy,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  frame_done,
  output logic                  frame_abort
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, ABORT, DRAIN} state_t;

  state_t             state;
  logic [IDX_W-1:0]   gidx, last_grant, pick_idx, cand;
  logic               pick_vld;
  logic [TO_W-1:0]    to_cnt;
  logic [NUM_REQ-1:0] hdr_rdy, t_rdy;

  logic [47:0] dst_a [NUM_REQ];
  logic [47:0] src_a [NUM_REQ];
  logic [15:0] typ_a [NUM_REQ];
  logic [7:0]  dat_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign dst_a[i] = bus.req_dest_mac[48*i +: 48];
    assign src_a[i] = bus.req_src_mac[48*i +: 48];
    assign typ_a[i] = bus.req_eth_type[16*i +: 16];
    assign dat_a[i] = bus.req_tdata[8*i +: 8];
  end

  // Round-robin: first pending requester after the previous owner.
  always_comb begin
    pick_idx = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!pick_vld && bus.req_hdr_valid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    hdr_rdy                       = '0;
    t_rdy                         = '0;
    bus.s_eth_hdr_valid           = 1'b0;
    bus.s_eth_dest_mac            = '0;
    bus.s_eth_src_mac             = '0;
    bus.s_eth_type                = '0;
    bus.s_eth_payload_axis_tdata  = '0;
    bus.s_eth_payload_axis_tvalid = 1'b0;
    bus.s_eth_payload_axis_tlast  = 1'b0;
    bus.s_eth_payload_axis_tuser  = 1'b0;
    case (state)
      HDR: begin
        bus.s_eth_hdr_valid = bus.req_hdr_valid[gidx];
        bus.s_eth_dest_mac  = dst_a[gidx];
        bus.s_eth_src_mac   = src_a[gidx];
        bus.s_eth_type      = typ_a[gidx];
        hdr_rdy[gidx]       = bus.s_eth_hdr_ready;
      end
      PAYLOAD: begin
        bus.s_eth_payload_axis_tdata  = dat_a[gidx];
        bus.s_eth_payload_axis_tvalid = bus.req_tvalid[gidx];
        bus.s_eth_payload_axis_tlast  = bus.req_tlast[gidx];
        t_rdy[gidx]                   = bus.s_eth_payload_axis_tready;
      end
      ABORT: begin
        bus.s_eth_payload_axis_tvalid = 1'b1;
        bus.s_eth_payload_axis_tlast  = 1'b1;
        bus.s_eth_payload_axis_tuser  = 1'b1;
      end
      DRAIN:   t_rdy[gidx] = 1'b1;
      default: ;
    endcase
  end

  assign bus.req_hdr_ready = hdr_rdy;
  assign bus.req_tready    = t_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      gidx        <= '0;
      last_grant  <= IDX_W'(NUM_REQ - 1);
      grant       <= '0;
      to_cnt      <= '0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      case (state)
        IDLE: if (!arg_busy && pick_vld) begin
          gidx  <= pick_idx;
          grant <= ONE << pick_idx;
          state <= HDR;
        end
        HDR: if (bus.req_hdr_valid[gidx] && bus.s_eth_hdr_ready) begin
          to_cnt <= '0;
          state  <= PAYLOAD;
        end
        PAYLOAD: begin
          // A valid beat always clears the stall count, so a final beat beats the timeout.
          if (bus.req_tvalid[gidx]) begin
            to_cnt <= '0;
            if (bus.s_eth_payload_axis_tready && bus.req_tlast[gidx]) begin
              state      <= IDLE;
              grant      <= '0;
              last_grant <= gidx;
              frame_done <= 1'b1;
            end
          end else if (IDLE_TIMEOUT != 0) begin
            if (to_cnt == TO_LAST) begin
              to_cnt <= '0;
              state  <= ABORT;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
        end
        ABORT: if (bus.s_eth_payload_axis_tready) begin
          frame_abort <= 1'b1;
          state       <= DRAIN;
        end
        DRAIN: if (bus.req_tvalid[gidx] && bus.req_tlast[gidx]) begin
          state      <= IDLE;
          grant      <= '0;
          last_grant <= gidx;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
